// File: rtl/fft_pkg.sv
// Shared types and widths for the radix-2 SDF FFT pipeline stages.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FIRST   = 2'b01,
    ST_SECOND  = 2'b10,
    ST_WAITING = 2'b11
  } bf_state_e;

  typedef enum logic [1:0] {
    WN_ZERO  = 2'b00,
    WN_ONE   = 2'b01,
    WN_TWO   = 2'b10,
    WN_THREE = 2'b11
  } wn_code_e;

  localparam int FFT_A_W    = 16;
  localparam int FFT_DW     = 17;
  localparam int FFT_FRAC_W = 6;
  localparam int FFT_N      = 32;

endpackage

// File: rtl/fft_sdf_delay_line.sv
// Complex feedback shift register with synchronous clear; shifts only when en is high.
module fft_sdf_delay_line
  import fft_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = FFT_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i
);

  logic [DW-1:0] tap_r_q [DEPTH];
  logic [DW-1:0] tap_i_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tap_r_q[i] <= '0;
        tap_i_q[i] <= '0;
      end
    end else if (en) begin
      tap_r_q[0] <= din_r;
      tap_i_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        tap_r_q[i] <= tap_r_q[i-1];
        tap_i_q[i] <= tap_i_q[i-1];
      end
    end
  end

  assign dout_r = tap_r_q[DEPTH-1];
  assign dout_i = tap_i_q[DEPTH-1];

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer, feedback delay line and output register for one radix-2 SDF FFT stage.
// Sticky output-overflow detection is built only when FFT_STAGE_OVF_EN is defined.
module fft_sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int DELAY = 2,
  parameter int N     = FFT_N,
  parameter int DW    = FFT_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic [1:0]    state,
  output logic [1:0]    wn,
  output logic [3:0]    tw_idx,
  output logic [DW-1:0] b_r,
  output logic [DW-1:0] b_i,
  input  logic [DW-1:0] sr_r,
  input  logic [DW-1:0] sr_i,
  input  logic [DW-1:0] bf_r,
  input  logic [DW-1:0] bf_i,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_i,
  output logic          out_valid,
  output logic          ovf
);

  localparam int PW    = $clog2(2*DELAY);
  localparam int TW_SH = $clog2(16/DELAY);

  if (N % (2*DELAY) != 0) begin : g_bad_n
    $error("fft_sdf_stage_ctrl: N must be a multiple of 2*DELAY");
  end

  bf_state_e     state_c;
  logic [PW-1:0] p_q, p_d;
  logic          primed_q, primed_d;
  logic          drain_q, drain_d;
  logic          drain, adv, drain_done, out_vld_d;
  logic [3:0]    tw_c;
  logic [DW-1:0] out_r_q, out_i_q;
  logic          out_valid_q;

  // Since 2*DELAY is a power of two, the counter MSB alone marks the FIRST half.
  always_comb begin
    drain      = drain_q | (primed_q & (p_q == '0) & ~in_valid);
    adv        = in_valid | drain;
    drain_done = drain & ~in_valid & (p_q == PW'(DELAY-1));
    p_d        = p_q;
    primed_d   = primed_q;
    drain_d    = drain_q;

    if (!adv && !primed_q)  state_c = ST_IDLE;
    else if (p_q[PW-1])     state_c = ST_FIRST;
    else if (primed_q)      state_c = ST_SECOND;
    else                    state_c = ST_WAITING;

    if (adv) begin
      p_d     = p_q + 1'b1;
      drain_d = ~in_valid;
      if (state_c == ST_FIRST) primed_d = 1'b1;
      if (drain_done) begin
        p_d      = '0;
        primed_d = 1'b0;
        drain_d  = 1'b0;
      end
    end
  end

  // Within SECOND k < DELAY, so the quadrant 4k/(2*DELAY) is just the index MSB.
  assign tw_c      = (state_c == ST_SECOND) ? (4'(p_q) << TW_SH) : 4'd0;
  assign tw_idx    = tw_c;
  assign wn        = {1'b0, tw_c[3]};
  assign state     = state_c;
  assign out_vld_d = adv & ((state_c == ST_FIRST) | (state_c == ST_SECOND));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q         <= '0;
      primed_q    <= 1'b0;
      drain_q     <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      primed_q    <= primed_d;
      drain_q     <= drain_d;
      out_r_q     <= bf_r;
      out_i_q     <= bf_i;
      out_valid_q <= out_vld_d;
    end
  end

  fft_sdf_delay_line #(
    .DEPTH (DELAY),
    .DW    (DW)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (adv),
    .din_r  (sr_r),
    .din_i  (sr_i),
    .dout_r (b_r),
    .dout_i (b_i)
  );

  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_valid = out_valid_q;

`ifdef FFT_STAGE_OVF_EN
  logic ovf_q, was_idle_q, ovf_hit;

  // A word fits in DW-1 bits only when its top two bits agree.
  assign ovf_hit = out_vld_d & ((bf_r[DW-1] ^ bf_r[DW-2]) | (bf_i[DW-1] ^ bf_i[DW-2]));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      was_idle_q <= 1'b1;
    end else begin
      was_idle_q <= (state_c == ST_IDLE);
      if (ovf_hit)                                  ovf_q <= 1'b1;
      else if (was_idle_q && (state_c != ST_IDLE))  ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Directed bench for fft_sdf_stage_ctrl (DELAY=2) with a behavioural stage butterfly beside it.
module tb_fft_sdf_stage_ctrl;

  localparam int DW = 17;
  localparam int S_IDLE = 0, S_FIRST = 1, S_SECOND = 2, S_WAIT = 3;
`ifdef FFT_STAGE_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic signed [15:0] a_r, a_i;
  logic [1:0]    state, wn;
  logic [3:0]    tw_idx;
  logic [DW-1:0] b_r, b_i, sr_r, sr_i, bf_r, bf_i, out_r, out_i;
  logic          out_valid, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_sdf_stage_ctrl #(.DELAY(2), .N(32), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .state     (state),
    .wn        (wn),
    .tw_idx    (tw_idx),
    .b_r       (b_r),
    .b_i       (b_i),
    .sr_r      (sr_r),
    .sr_i      (sr_i),
    .bf_r      (bf_r),
    .bf_i      (bf_i),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  // Stage butterfly: FIRST emits b+a and feeds back b-a; other states pass b on and store a.
  logic signed [DW-1:0] ar_x, ai_x, br_s, bi_s;
  always_comb begin
    ar_x = {a_r[15], a_r};
    ai_x = {a_i[15], a_i};
    br_s = b_r;
    bi_s = b_i;
    bf_r = br_s;
    bf_i = bi_s;
    sr_r = ar_x;
    sr_i = ai_x;
    if (state == 2'(S_FIRST)) begin
      bf_r = br_s + ar_x;
      bf_i = bi_s + ai_x;
      sr_r = br_s - ar_x;
      sr_i = bi_s - ai_x;
    end else if (state == 2'(S_IDLE)) begin
      bf_r = '0;
      bf_i = '0;
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One input cycle; for DELAY=2 the SECOND twiddle index is 8*k and wn is k.
  task automatic cyc(input logic v, input int ar, input int e_st, input int e_wn,
                     input int e_b, input logic e_ov, input int e_out);
    @(negedge clk);
    in_valid = v;
    a_r      = 16'(ar);
    #1;
    check_val("state", int'(state), e_st);
    check_val("wn", int'(wn), e_wn);
    check_val("tw_idx", int'(tw_idx), 8 * e_wn);
    check_val("b_r", int'($signed(b_r)), e_b);
    check_val("out_valid", int'(out_valid), int'(e_ov));
    if (e_ov) begin
      check_val("out_r", int'($signed(out_r)), e_out);
      check_val("out_i", int'($signed(out_i)), 0);
    end
  endtask

  task automatic frame_a();
    cyc(1,  64, S_WAIT,   0,    0, 0,    0);
    cyc(1, 128, S_WAIT,   0,    0, 0,    0);
    cyc(1, 192, S_FIRST,  0,   64, 0,    0);
    cyc(1, 256, S_FIRST,  0,  128, 1,  256);
    cyc(0,   0, S_SECOND, 0, -128, 1,  384);
    cyc(0,   0, S_SECOND, 1, -128, 1, -128);
    cyc(0,   0, S_IDLE,   0,    0, 1, -128);
    cyc(0,   0, S_IDLE,   0,    0, 0,    0);
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a_r      = '0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a_r      = '0;
    a_i      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_state", int'(state), S_IDLE);
    check_val("rst_b_r", int'(b_r), 0);
    check_val("rst_out_r", int'(out_r), 0);
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;

    // Single frame with drain
    frame_a();

    // Two frames back to back
    cyc(1,  64, S_WAIT,   0,    0, 0,    0);
    cyc(1, 128, S_WAIT,   0,    0, 0,    0);
    cyc(1, 192, S_FIRST,  0,   64, 0,    0);
    cyc(1, 256, S_FIRST,  0,  128, 1,  256);
    cyc(1,  10, S_SECOND, 0, -128, 1,  384);
    cyc(1,  20, S_SECOND, 1, -128, 1, -128);
    cyc(1,  30, S_FIRST,  0,   10, 1, -128);
    cyc(1,  40, S_FIRST,  0,   20, 1,   40);
    cyc(0,   0, S_SECOND, 0,  -20, 1,   60);
    cyc(0,   0, S_SECOND, 1,  -20, 1,  -20);
    cyc(0,   0, S_IDLE,   0,    0, 1,  -20);
    cyc(0,   0, S_IDLE,   0,    0, 0,    0);

    // Stall for three cycles after the first sample
    cyc(1,  64, S_WAIT,   0,    0, 0,    0);
    for (int i = 0; i < 3; i++) cyc(0, 0, S_IDLE, 0, 0, 0, 0);
    cyc(1, 128, S_WAIT,   0,    0, 0,    0);
    cyc(1, 192, S_FIRST,  0,   64, 0,    0);
    cyc(1, 256, S_FIRST,  0,  128, 1,  256);
    cyc(0,   0, S_SECOND, 0, -128, 1,  384);
    cyc(0,   0, S_SECOND, 1, -128, 1, -128);
    cyc(0,   0, S_IDLE,   0,    0, 1, -128);
    cyc(0,   0, S_IDLE,   0,    0, 0,    0);

    // Reset in the middle of FIRST abandons the frame
    cyc(1,  64, S_WAIT,   0,    0, 0,    0);
    cyc(1, 128, S_WAIT,   0,    0, 0,    0);
    cyc(1, 192, S_FIRST,  0,   64, 0,    0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a_r      = 16'sd256;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a_r      = '0;
    #1;
    check_val("midrst_state", int'(state), S_IDLE);
    check_val("midrst_b_r", int'(b_r), 0);
    check_val("midrst_out_valid", int'(out_valid), 0);
    check_val("midrst_out_r", int'(out_r), 0);
    cyc(0, 0, S_IDLE, 0, 0, 0, 0);
    frame_a();

    // Overflow on the FIRST sum
    cyc(1, 32767, S_WAIT,   0,     0, 0,     0);
    cyc(1,     0, S_WAIT,   0,     0, 0,     0);
    cyc(1, 32767, S_FIRST,  0, 32767, 0,     0);
    cyc(1,     0, S_FIRST,  0,     0, 1, 65534);
    check_val("ovf_set", int'(ovf), int'(OVF_EXP));
    cyc(0,     0, S_SECOND, 0,     0, 1,     0);
    cyc(0,     0, S_SECOND, 1,     0, 1,     0);
    cyc(0,     0, S_IDLE,   0,     0, 1,     0);
    cyc(0,     0, S_IDLE,   0,     0, 0,     0);
    check_val("ovf_hold", int'(ovf), int'(OVF_EXP));
    pulse_reset(1);
    check_val("ovf_rst", int'(ovf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
